// File: rtl/tc_abs_16_rr_sched.sv
// tc_abs_16_rr_sched
//   Round-robin front end that shares a single tc_abs_16 datapath among NREQ
//   fixed-point stream producers. Two pipeline stages: an operand register (s1)
//   feeding tc_abs_16 combinationally, then a result register that holds the
//   tagged response under valid/ready back-pressure.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   req_valid     [NREQ]      per-requester operand valid
//   req_data      [NREQ][16]  operand i in req_data[i], two's complement
//   req_ready     [NREQ]      one-hot accept; all zero when stage 1 cannot take
//   resp_valid    result valid
//   resp_data     |operand| (16 bit)
//   resp_tag      [TAG_W] index of the requester that issued the result
//   resp_ready    consumer accepts result
//   busy          any stage holds an operand
//
// Configuration
//   TC_ABS_SAT_EN  when defined, abs(0x8000) saturates to 0x7FFF in stage 2;
//                  otherwise it wraps to 0x8000. No port/latency change.

module tc_abs_16 (
  input  logic [15:0] a,
  output logic [15:0] fs_0
);
  assign fs_0 = a[15] ? (~a + 16'd1) : a;
endmodule

module tc_abs_16_rr_sched #(
  parameter int NREQ  = 4,
  parameter int TAG_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0][15:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  resp_valid,
  output logic [15:0]           resp_data,
  output logic [TAG_W-1:0]      resp_tag,
  input  logic                  resp_ready,
  output logic                  busy
);

  logic             s1_valid;
  logic [15:0]      op_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [TAG_W-1:0] rr_ptr;

  logic             adv1, acc, xfer, found;
  logic [NREQ-1:0]  win;
  logic [TAG_W-1:0] win_idx;
  logic [15:0]      fs_0, res;

  // Stage 1 moves when the result register is empty or being drained;
  // stage 1 can take a new operand whenever it is empty or moving.
  assign adv1 = s1_valid & (~resp_valid | resp_ready);
  assign acc  = ~s1_valid | adv1;

  // Scan from rr_ptr upward, wrapping at NREQ (not at 2**TAG_W), so a
  // non-power-of-two NREQ never yields an out-of-range index.
  always_comb begin
    logic [TAG_W:0] idx;
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, rr_ptr} + (TAG_W+1)'(k);
      if (idx >= (TAG_W+1)'(NREQ)) idx = idx - (TAG_W+1)'(NREQ);
      if (!found && req_valid[idx[TAG_W-1:0]]) begin
        found   = 1'b1;
        win_idx = idx[TAG_W-1:0];
      end
    end
    if (found) win[win_idx] = 1'b1;
  end

  assign req_ready = win & {NREQ{acc}};
  assign xfer      = found & acc;
  assign busy      = s1_valid | resp_valid;

  tc_abs_16 u_abs (
    .a    (op_reg),
    .fs_0 (fs_0)
  );

`ifdef TC_ABS_SAT_EN
  // Only the most-negative input overflows; clamp it to the largest positive.
  assign res = (fs_0 == 16'h8000) ? 16'h7FFF : fs_0;
`else
  assign res = fs_0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      op_reg     <= '0;
      tag_reg    <= '0;
      rr_ptr     <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_tag   <= '0;
    end else begin
      // A new transfer refills stage 1 in the same edge it advances.
      if (xfer) begin
        op_reg   <= req_data[win_idx];
        tag_reg  <= win_idx;
        s1_valid <= 1'b1;
        rr_ptr   <= (win_idx == TAG_W'(NREQ-1)) ? '0 : win_idx + 1'b1;
      end else if (adv1) begin
        s1_valid <= 1'b0;
      end

      if (adv1) begin
        resp_data  <= res;
        resp_tag   <= tag_reg;
        resp_valid <= 1'b1;
      end else if (resp_valid && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tc_abs_16_rr_sched.sv
// tb_tc_abs_16_rr_sched
//   Randomized and directed stimulus against a transaction-level model:
//   a FIFO of expected {result, tag} in flight, a round-robin pointer, and
//   an occupancy-based accept rule.

module tb_tc_abs_16_rr_sched;
  localparam int NREQ  = 4;
  localparam int TAG_W = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0][15:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  resp_valid;
  logic [15:0]           resp_data;
  logic [TAG_W-1:0]      resp_tag;
  logic                  resp_ready;
  logic                  busy;

  always #5 clk = ~clk;

  tc_abs_16_rr_sched #(.NREQ(NREQ), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_tag   (resp_tag),
    .resp_ready (resp_ready),
    .busy       (busy)
  );

  typedef struct {
    logic [15:0] d;
    int          tag;
  } item_t;

  item_t q[$];     // in-flight results, oldest first
  bit    m_out;    // oldest item already sits in the result register
  int    m_ptr;
  int    checks = 0;
  int    failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] abs_ref(input logic [15:0] x);
    int v;
    v = int'($signed(x));
    if (v < 0) v = -v;
`ifdef TC_ABS_SAT_EN
    if (v > 32767) v = 32767;
`endif
    return v[15:0];
  endfunction

  task automatic model_clear();
    q.delete();
    m_out = 0;
    m_ptr = 0;
  endtask

  // Drive one cycle of inputs, check against the model mid-cycle, then advance
  // the model across the rising edge.
  task automatic cyc(input logic [NREQ-1:0] v, input logic [NREQ-1:0][15:0] d,
                     input logic rr);
    bit acc, found, drain, moving;
    int win;
    logic [NREQ-1:0] exp_rdy;
    item_t it;
    req_valid = v; req_data = d; resp_ready = rr;
    @(negedge clk);
    acc = (q.size() < 2) || rr;
    found = 0; win = 0;
    for (int k = 0; k < NREQ; k++)
      if (!found && v[(m_ptr + k) % NREQ]) begin found = 1; win = (m_ptr + k) % NREQ; end
    exp_rdy = '0;
    if (found && acc) exp_rdy[win] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("resp_valid", 32'(resp_valid), 32'(m_out));
    chk("busy", 32'(busy), 32'(q.size() != 0));
    if (m_out) begin
      chk("resp_data", 32'(resp_data), 32'(q[0].d));
      chk("resp_tag", 32'(resp_tag), 32'(q[0].tag));
    end
    drain  = m_out && rr;
    moving = ((q.size() - int'(m_out)) == 1) && (!m_out || rr);
    if (drain) void'(q.pop_front());
    m_out = moving ? 1'b1 : (drain ? 1'b0 : m_out);
    if (found && acc) begin
      it.d = abs_ref(d[win]); it.tag = win;
      q.push_back(it);
      m_ptr = (win + 1) % NREQ;
    end
    @(posedge clk); #1;
  endtask

  // Reset for one edge with whatever inputs are present, then check the
  // post-reset state with all requests idle.
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '0; resp_ready = 1'b0;
    model_clear();
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    chk("rst_resp_tag", 32'(resp_tag), 32'd0);
  endtask

  logic [NREQ-1:0][15:0] dd;

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; resp_ready = 1'b0;
    model_clear();
    @(posedge clk); #1;
    do_reset();

    // Single request, latency check.
    dd = '0; dd[0] = 16'h0001;
    cyc(4'b0001, dd, 1'b1);
    cyc(4'b0000, dd, 1'b1);
    chk("lat_before_edge", 32'(resp_valid), 32'd1);
    chk("lat_data", 32'(resp_data), 32'h0001);
    cyc(4'b0000, dd, 1'b1);

    // All four streaming, one result per cycle, tags 0,1,2,3,...
    do_reset();
    dd[0] = 16'hFFFB; dd[1] = 16'd7; dd[2] = 16'hFED4; dd[3] = 16'd0;
    for (int i = 0; i < 10; i++) cyc(4'b1111, dd, 1'b1);
    chk("stream_inflight", 32'(q.size()), 32'd2);

    // Fill the pipe and stall five cycles, then drain.
    for (int i = 0; i < 5; i++) cyc(4'b1111, dd, 1'b0);
    for (int i = 0; i < 4; i++) cyc(4'b0000, dd, 1'b1);
    chk("drained", 32'(busy), 32'd0);

    // Most-negative operand.
    dd[1] = 16'h8000;
    cyc(4'b0010, dd, 1'b1);
    cyc(4'b0000, dd, 1'b1);
`ifdef TC_ABS_SAT_EN
    chk("abs_8000", 32'(resp_data), 32'h7FFF);
`else
    chk("abs_8000", 32'(resp_data), 32'h8000);
`endif
    cyc(4'b0000, dd, 1'b1);

    // Reset with both stages valid, then lowest valid index wins.
    for (int i = 0; i < 3; i++) cyc(4'b0100, dd, 1'b0);
    req_valid = 4'b0110;
    do_reset();
    cyc(4'b0110, dd, 1'b1);
    for (int i = 0; i < 3; i++) cyc(4'b0000, dd, 1'b1);

    // Req 2 pulses while stalled and drops; req 3 held and must win.
    dd[2] = 16'h0022; dd[3] = 16'h0033;
    do_reset();
    for (int i = 0; i < 3; i++) cyc(4'b0001, dd, 1'b0);
    cyc(4'b1100, dd, 1'b0);
    cyc(4'b1000, dd, 1'b0);
    cyc(4'b1000, dd, 1'b1);
    chk("pulse_ptr", 32'(m_ptr), 32'd0);
    for (int i = 0; i < 4; i++) cyc(4'b0000, dd, 1'b1);

    // Random traffic with occasional mid-operation reset.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        case ($urandom_range(0, 5))
          0: dd[i] = 16'h8000;
          1: dd[i] = 16'h0000;
          2: dd[i] = 16'h7FFF;
          default: dd[i] = 16'($urandom);
        endcase
      end
      if ($urandom_range(0, 99) == 0) begin
        req_valid = 4'($urandom);
        do_reset();
      end else begin
        cyc(4'($urandom), dd, ($urandom_range(0, 3) != 0));
      end
    end
    for (int i = 0; i < 4; i++) cyc(4'b0000, dd, 1'b1);
    chk("final_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
